// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S/TDM transmit path.
package i2s_pkg;

   localparam int unsigned LANE_W = 32;

   typedef enum logic [1:0] {
      SW16 = 2'b00,
      SW20 = 2'b01,
      SW24 = 2'b10,
      SW32 = 2'b11
   } sample_width_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   // Number of significant sample bits for a width code.
   function automatic logic [5:0] sw_bits(input sample_width_e sw);
      case (sw)
         SW16:    sw_bits = 6'd16;
         SW20:    sw_bits = 6'd20;
         SW24:    sw_bits = 6'd24;
         default: sw_bits = 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/i2s_tdm_tx_fifo.sv
// i2s_frame_fifo: single-clock frame FIFO with registered full/empty/level.
module i2s_frame_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic             do_push_c;
   logic             do_pop_c;
   logic [LW-1:0]    level_n_c;

   assign do_push_c = push && !full;
   assign do_pop_c  = pop && !empty;
   assign rdata_c   = mem_q[rd_ptr_q];

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      level_n_c = level;
      if (do_push_c && !do_pop_c)
         level_n_c = level + LW'(1);
      else if (!do_push_c && do_pop_c)
         level_n_c = level - LW'(1);
   end

   // Pointers and status flags, updated together so flags track level.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level <= level_n_c;
         full  <= (level_n_c == LW'(DEPTH));
         empty <= (level_n_c == '0);
      end
   end

   // Storage array; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: buffered I2S / TDM serialiser with BCLK/WCLK generation.
// Optional build macro I2S_UNDERRUN_REPEAT_EN: on underrun, resend the last
// popped frame instead of silence.
module i2s_tdm_tx
   import i2s_pkg::*;
#(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned SLOT_W     = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BCLK_DIV   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [1:0]                    sample_width,
   input  logic [NUM_CH*32-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   input  logic                          underrun_clr,
   output logic                          busy,
   output logic                          i2s_bclk,
   output logic                          i2s_wclk,
   output logic                          i2s_data
);

   localparam int unsigned FRAME_W = NUM_CH * LANE_W;
   localparam int unsigned CNT_W   = $clog2(BCLK_DIV);
   localparam int unsigned POS_W   = $clog2(SLOT_W);
   localparam int unsigned SLOT_IW = $clog2(NUM_CH);

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BCLK_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_HALF  = CNT_W'(BCLK_DIV / 2);
   localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(SLOT_W - 1);
   localparam logic [SLOT_IW-1:0] SLOT_LAST = SLOT_IW'(NUM_CH - 1);
   localparam logic [SLOT_IW-1:0] SLOT_HALF = SLOT_IW'(NUM_CH / 2);

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [POS_W-1:0]     pos_q;
   logic [SLOT_IW-1:0]   slot_q;
   logic                 tail_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [5:0]           width_q;

   logic [FRAME_W-1:0]   fifo_rdata_c;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [FRAME_W-1:0]   fill_frame_c;
   logic [FRAME_W-1:0]   next_frame_c;
   logic [CNT_W-1:0]     cnt_n_c;
   logic                 fall_c;
   logic                 frame_end_c;
   logic                 pop_c;
   logic                 uflow_c;
   logic [5:0]           width_c;
   logic [LANE_W-1:0]    lane_c;
   logic [4:0]           bit_idx_c;
   logic                 stream_c;

   i2s_frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (s_valid),
      .pop     (pop_c),
      .wdata   (s_data),
      .rdata_c (fifo_rdata_c),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign s_ready = !fifo_full;

   // Divider and framing events.
   assign fall_c      = (state_q != IDLE) && (cnt_q == CNT_LAST);
   assign cnt_n_c     = fall_c ? '0 : cnt_q + CNT_W'(1);
   assign frame_end_c = (slot_q == SLOT_LAST) && (pos_q == POS_LAST);
   assign pop_c       = enable && ((state_q == IDLE) || (fall_c && !tail_q && frame_end_c));
   assign uflow_c     = pop_c && fifo_empty;

`ifdef I2S_UNDERRUN_REPEAT_EN
   logic [FRAME_W-1:0] last_frame_q;

   // Remember the most recent frame actually taken from the FIFO.
   always_ff @(posedge clk) begin
      if (reset)
         last_frame_q <= '0;
      else if (pop_c && !fifo_empty)
         last_frame_q <= fifo_rdata_c;
   end

   assign fill_frame_c = last_frame_q;
`else
   assign fill_frame_c = '0;
`endif

   assign next_frame_c = fifo_empty ? fill_frame_c : fifo_rdata_c;

   // Requested sample width, clamped to the slot length.
   always_comb begin
      width_c = sw_bits(sample_width_e'(sample_width));
      if (32'(width_c) > SLOT_W) width_c = 6'(SLOT_W);
   end

   // Select the lane of the current slot.
   always_comb begin
      lane_c = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (slot_q == SLOT_IW'(k)) lane_c = frame_q[k*LANE_W +: LANE_W];
      end
   end

   // Undelayed stream bit: sample MSB first, zero-padded to the slot end.
   always_comb begin
      bit_idx_c = 5'(width_q - 6'(pos_q) - 6'd1);
      stream_c  = 1'b0;
      if (6'(pos_q) < width_q) stream_c = lane_c[bit_idx_c];
   end

   // Transmit FSM, clock divider, bit counters and pin drivers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pos_q    <= '0;
         slot_q   <= '0;
         tail_q   <= 1'b0;
         frame_q  <= '0;
         width_q  <= '0;
         busy     <= 1'b0;
         i2s_bclk <= 1'b0;
         i2s_wclk <= 1'b0;
         i2s_data <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q    <= '0;
               i2s_bclk <= 1'b0;
               i2s_wclk <= 1'b0;
               i2s_data <= 1'b0;
               if (enable) begin
                  state_q <= RUN;
                  busy    <= 1'b1;
                  pos_q   <= '0;
                  slot_q  <= '0;
                  tail_q  <= 1'b0;
                  frame_q <= next_frame_c;
                  width_q <= width_c;
               end
            end
            RUN, STOP: begin
               cnt_q    <= cnt_n_c;
               i2s_bclk <= (cnt_n_c >= CNT_HALF);
               if (state_q == RUN && !enable) state_q <= STOP;
               if (fall_c) begin
                  if (tail_q) begin
                     state_q  <= IDLE;
                     busy     <= 1'b0;
                     tail_q   <= 1'b0;
                     i2s_data <= 1'b0;
                     i2s_wclk <= 1'b0;
                  end else begin
                     i2s_data <= stream_c;
                     if (frame_end_c) begin
                        pos_q    <= '0;
                        slot_q   <= '0;
                        i2s_wclk <= 1'b0;
                        if (enable) begin
                           state_q <= RUN;
                           frame_q <= next_frame_c;
                           width_q <= width_c;
                        end else begin
                           state_q <= STOP;
                           tail_q  <= 1'b1;
                        end
                     end else if (pos_q == POS_LAST) begin
                        pos_q    <= '0;
                        slot_q   <= slot_q + SLOT_IW'(1);
                        i2s_wclk <= ((slot_q + SLOT_IW'(1)) >= SLOT_HALF);
                     end else begin
                        pos_q <= pos_q + POS_W'(1);
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Sticky underrun flag; a new underrun beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset)
         underrun <= 1'b0;
      else if (uflow_c)
         underrun <= 1'b1;
      else if (underrun_clr)
         underrun <= 1'b0;
   end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: directed, table-driven bench for i2s_tdm_tx.
`timescale 1ns/1ps
module tb_i2s_tdm_tx;

   localparam int BOUND = 64;

   logic         clk = 1'b0;
   logic         reset, enable, underrun_clr;
   logic [1:0]   sample_width;
   logic [63:0]  s_data;
   logic         s_valid, s_ready, underrun, busy, bclk, wclk, data;
   logic [4:0]   fifo_level;
   logic [127:0] s_data4;
   logic         s_valid4, s_ready4, underrun4, busy4, bclk4, wclk4, data4;
   logic [2:0]   fifo_level4;

   int n_checks;
   int n_fail;
   logic dq [256];
   logic wq [256];

   always #5 clk = ~clk;

   i2s_tdm_tx dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_width(sample_width),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .fifo_level(fifo_level),
      .underrun(underrun), .underrun_clr(underrun_clr), .busy(busy),
      .i2s_bclk(bclk), .i2s_wclk(wclk), .i2s_data(data)
   );

   i2s_tdm_tx #(.NUM_CH(4), .SLOT_W(16), .FIFO_DEPTH(4), .BCLK_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .sample_width(sample_width),
      .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4), .fifo_level(fifo_level4),
      .underrun(underrun4), .underrun_clr(underrun_clr), .busy(busy4),
      .i2s_bclk(bclk4), .i2s_wclk(wclk4), .i2s_data(data4)
   );

   typedef struct {
      logic [1:0]  sw;
      logic [31:0] l;
      logic [31:0] r;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound of %0d cycles expired", name, BOUND);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic push(input bit sel, input logic [127:0] d);
      if (sel) begin s_data4 = d; s_valid4 = 1'b1; end
      else     begin s_data = d[63:0]; s_valid = 1'b1; end
      @(posedge clk);
      #1;
      s_valid  = 1'b0;
      s_valid4 = 1'b0;
   endtask

   // Record wclk/data once per BCLK period at each bclk rising edge.
   task automatic capture(input bit sel, input int n, input int drop_at,
                          input int chg_at, input logic [1:0] chg_sw);
      logic prev, cur, found;
      int   t;
      for (int k = 0; k < n; k++) begin
         prev  = sel ? bclk4 : bclk;
         found = 1'b0;
         t     = 0;
         while (!found && t <= BOUND) begin
            @(negedge clk);
            cur = sel ? bclk4 : bclk;
            if (!prev && cur) found = 1'b1;
            prev = cur;
            t++;
         end
         if (!found) begin
            timeout("bclk_edge");
            enable = 1'b0;
            return;
         end
         wq[k] = sel ? wclk4 : wclk;
         dq[k] = sel ? data4 : data;
         if (k + 1 == drop_at) enable = 1'b0;
         if (k + 1 == chg_at)  sample_width = chg_sw;
      end
   endtask

   // Data of period start+1+i is undelayed bit i; wclk of period start+i is bit i's slot.
   task automatic check_frame(input string name, input int start, input logic [63:0] exp);
      logic [63:0] gd, gw;
      for (int i = 0; i < 64; i++) begin
         gd[63-i] = dq[start+1+i];
         gw[63-i] = wq[start+i];
      end
      check({name, "_data"}, gd, exp);
      check({name, "_wclk"}, gw, 64'h00000000_FFFFFFFF);
   endtask

   task automatic wait_idle(input bit sel, input string name);
      int t;
      t = 0;
      @(negedge clk);
      while ((sel ? busy4 : busy) && t < BOUND) begin
         @(negedge clk);
         t++;
      end
      if (sel ? busy4 : busy) timeout({name, "_idle"});
      else check({name, "_bclk_idle"}, 64'(sel ? bclk4 : bclk), 64'd0);
   endtask

   task automatic run_one(input bit sel, input logic [1:0] sw, input logic [63:0] exp,
                          input logic exp_ur, input string name);
      sample_width = sw;
      enable       = 1'b1;
      capture(sel, 65, 1, -1, 2'b00);
      check({name, "_lead"}, 64'(dq[0]), 64'd0);
      check_frame(name, 0, exp);
      wait_idle(sel, name);
      check({name, "_underrun"}, 64'(sel ? underrun4 : underrun), 64'(exp_ur));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rep_exp;
      int          rises;
      logic        prevb;

      n_checks = 0;
      n_fail   = 0;
      vecs[0] = '{2'b10, 32'h0012_3456, 32'h00AB_CDEF, 64'h12345600_ABCDEF00};
      vecs[1] = '{2'b00, 32'h0000_AAAA, 32'h0000_5555, 64'hAAAA0000_55550000};
      vecs[2] = '{2'b11, 32'hDEAD_BEEF, 32'h0123_4567, 64'hDEADBEEF_01234567};
      vecs[3] = '{2'b01, 32'h000A_BCDE, 32'h0001_2345, 64'hABCDE000_12345000};
      vecs[4] = '{2'b00, 32'hFFFF_1234, 32'h8000_C001, 64'h12340000_C0010000};

      reset = 1'b1; enable = 1'b0; underrun_clr = 1'b0; sample_width = 2'b00;
      s_data = '0; s_valid = 1'b0; s_data4 = '0; s_valid4 = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_s_ready",  64'(s_ready),    64'd1);
      check("rst_level",    64'(fifo_level), 64'd0);
      check("rst_underrun", 64'(underrun),   64'd0);
      check("rst_busy",     64'(busy),       64'd0);
      check("rst_bclk",     64'(bclk),       64'd0);
      check("rst_wclk",     64'(wclk),       64'd0);
      check("rst_data",     64'(data),       64'd0);

      // Single frames at each width, one frame buffered per run.
      for (int v = 0; v < 5; v++) begin
         push(1'b0, {64'd0, vecs[v].r, vecs[v].l});
         run_one(1'b0, vecs[v].sw, vecs[v].exp, 1'b0, $sformatf("vec%0d", v));
      end

      // Empty-FIFO start: push in the same cycle is kept, clear loses to set.
      do_reset();
      sample_width = 2'b00;
      s_data       = {32'h0000_5555, 32'h0000_AAAA};
      s_valid      = 1'b1;
      underrun_clr = 1'b1;
      enable       = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0; underrun_clr = 1'b0;
      @(negedge clk);
      check("ur_set_wins",  64'(underrun),   64'd1);
      check("ur_push_kept", 64'(fifo_level), 64'd1);
      capture(1'b0, 129, 70, -1, 2'b00);
      check_frame("ur_zero", 0, 64'd0);
      check_frame("ur_next", 64, 64'hAAAA0000_55550000);
      wait_idle(1'b0, "ur");
      check("ur_sticky", 64'(underrun), 64'd1);
      underrun_clr = 1'b1;
      @(posedge clk);
      #1 underrun_clr = 1'b0;
      @(negedge clk);
      check("ur_cleared", 64'(underrun), 64'd0);
      push(1'b0, {64'd0, 32'h0000_5555, 32'h0000_AAAA});
      run_one(1'b0, 2'b00, 64'hAAAA0000_55550000, 1'b0, "ur_good");
`ifdef I2S_UNDERRUN_REPEAT_EN
      rep_exp = 64'hAAAA0000_55550000;
`else
      rep_exp = 64'd0;
`endif
      run_one(1'b0, 2'b00, rep_exp, 1'b1, "ur_fill");

      // Full FIFO, ignored push, s_ready after the first pop, reset mid-frame.
      do_reset();
      for (int i = 0; i < 16; i++) push(1'b0, {64'd0, ~32'(i), 32'(i)});
      @(negedge clk);
      check("full_level", 64'(fifo_level), 64'd16);
      check("full_ready", 64'(s_ready),    64'd0);
      push(1'b0, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      @(negedge clk);
      check("full_ignored", 64'(fifo_level), 64'd16);
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("pop_ready", 64'(s_ready),    64'd1);
      check("pop_level", 64'(fifo_level), 64'd15);
      repeat (100) @(posedge clk);
      #1;
      check("mid_busy", 64'(busy), 64'd1);
      reset = 1'b1; enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mrst_outs", 64'({busy, bclk, wclk, data, underrun}), 64'd0);
      check("mrst_level", 64'(fifo_level), 64'd0);
      check("mrst_ready", 64'(s_ready),    64'd1);
      #1 reset = 1'b0;

      // Enable dropped at bit 10: frame completes, one trailing bit, then quiet.
      push(1'b0, {64'd0, vecs[0].r, vecs[0].l});
      sample_width = vecs[0].sw;
      enable       = 1'b1;
      capture(1'b0, 65, 11, -1, 2'b00);
      check_frame("stop10", 0, vecs[0].exp);
      check("stop10_tail", 64'(dq[64]), 64'd0);
      wait_idle(1'b0, "stop10");
      rises = 0;
      prevb = bclk;
      repeat (40) begin
         @(negedge clk);
         if (!prevb && bclk) rises++;
         prevb = bclk;
      end
      check("stop10_quiet", 64'(rises), 64'd0);

      // Width change mid-frame applies from the next frame.
      do_reset();
      push(1'b0, {64'd0, 32'h0123_4567, 32'hDEAD_BEEF});
      push(1'b0, {64'd0, 32'h89AB_7654, 32'hCAFE_F00D});
      sample_width = 2'b11;
      enable       = 1'b1;
      capture(1'b0, 129, 70, 20, 2'b00);
      check_frame("swchg_f1", 0, 64'hDEADBEEF_01234567);
      check_frame("swchg_f2", 64, 64'hF00D0000_76540000);
      check("swchg_tail", 64'(dq[128]), 64'd0);
      wait_idle(1'b0, "swchg");

      // Four-channel TDM with 16-bit slots, then a width clamped to the slot.
      do_reset();
      push(1'b1, {32'h1234_7788, 32'h0000_0E0F, 32'hFFFF_C3D4, 32'h0000_A1B2});
      run_one(1'b1, 2'b00, 64'hA1B2C3D4_0E0F7788, 1'b0, "tdm16");
      do_reset();
      push(1'b1, {32'h00FF_0001, 32'h0000_5A5A, 32'h00AB_CDEF, 32'h00FF_1234});
      run_one(1'b1, 2'b10, 64'h1234CDEF_5A5A0001, 1'b0, "tdm_clamp");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised successor to the fixed stereo I2S path in the codec unit. It buffers multi-channel audio frames in an internal FIFO and generates BCLK/WCLK from the system clock. It serialises NUM_CH slots per frame in I2S (2-channel) or 50%-duty TDM (>2 channels) format, with a run-time sample width and underrun detection. It sits between the sample-producing logic and the CODEC pins, replacing the separate FIFO and I2S controller pair.

Parameters:
NUM_CH, 2, channels (slots) per frame; even, 2..8
SLOT_W, 32, bit clocks per slot; 16..32
FIFO_DEPTH, 16, frames buffered; power of 2, >=4
BCLK_DIV, 8, clk cycles per BCLK period; even, >=4

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high
enable  in  1  run request; level-sensitive
sample_width  in  2  00=16, 01=20, 10=24, 11=32 bits; sampled at frame start
s_data  in  NUM_CH*32  one frame; lane k = bits [32k+31:32k], sample right-justified in lane
s_valid  in  1  frame valid
s_ready  out  1  FIFO not full
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored
underrun  out  1  sticky underrun flag
underrun_clr  in  1  clears underrun
busy  out  1  state != IDLE
i2s_bclk  out  1  bit clock
i2s_wclk  out  1  word/frame select
i2s_data  out  1  serial data

Behaviour:
- Reset: all outputs 0 except s_ready=1. FIFO is emptied, state is IDLE, the divider and bit counter are 0, and underrun is cleared.
- FIFO push: a frame is pushed when s_valid && s_ready. s_ready = !full, registered the same cycle as the level changes.
- States:
  - IDLE: bclk, wclk and data are held 0. When enable=1, go to RUN on the next clk.
  - RUN: on the IDLE->RUN transition and at every frame wrap, pop one frame and latch sample_width.
  - STOP: entered when enable=0 is seen in RUN. The current frame completes, then the final delayed data bit is output for one more BCLK period, then IDLE.
  - STOP with enable=1 again: re-enter RUN at the next frame boundary.
- Divider:
  - cnt counts 0..BCLK_DIV-1.
  - i2s_bclk = (cnt >= BCLK_DIV/2), registered.
  - The falling-edge event is cnt wrapping to 0. All data and wclk updates occur on that event.
- Bit counter:
  - b runs 0..NUM_CH*SLOT_W-1 and advances on each falling event.
  - Slot = b / SLOT_W; bit within slot is MSB first.
  - Slot bits beyond the sample width are 0.
  - Sample width is clamped to SLOT_W if larger.
- Framing:
  - Undelayed stream bit = sample[W-1-(b%SLOT_W)] while b%SLOT_W < W, else 0.
  - i2s_data = undelayed stream delayed by one BCLK period (standard I2S one-bit delay).
  - i2s_wclk = 0 for slots 0..NUM_CH/2-1 and 1 for the rest, aligned to the undelayed stream, so it changes one BCLK before each MSB.
- Underrun:
  - If the FIFO is empty at a pop point, the frame is all zeros and underrun is set.
  - A push in the same cycle as an empty pop is stored for the next frame; it does not rescue the current frame.
  - If underrun_clr is asserted in the same cycle as a new underrun, set wins.
- Pop at full: the pop frees an entry and s_ready rises on the next cycle.
- Reset mid-frame: immediate return to the reset state; buffered frames are lost.
- sample_width changes mid-frame take effect at the next pop only.

Optional Feature:
- Macro: I2S_UNDERRUN_REPEAT_EN.
- Defined: on underrun, the last successfully popped frame is retransmitted instead of zeros. If no frame has been popped since reset, zeros are sent. underrun is still set.
- Undefined: zeros are sent on underrun, as above.

Decomposition:
- Package i2s_pkg holds:
  - sample_width_e enum (SW16, SW20, SW24, SW32)
  - LANE_W=32 constant
  - function sw_bits(sample_width_e) returning 16/20/24/32
  - state_e enum (IDLE, RUN, STOP)
- Sub-module i2s_frame_fifo: synchronous, single-clock FIFO of width NUM_CH*32 and depth FIFO_DEPTH, with full, empty and level outputs.

Test Plan:
1. Default parameters, SW24; push frame L=0x123456, R=0xABCDEF; enable. Required: i2s_wclk low for 32 BCLKs, then high for 32. MSB of L appears one BCLK after wclk falls, followed by bits 0x123456 and 8 zeros. R follows in the same pattern.
2. Enable with an empty FIFO. Required: the frame is all zeros and underrun=1. After underrun_clr and then a push, a good frame follows with underrun=0. With I2S_UNDERRUN_REPEAT_EN, after one good frame 0xAAAA/0x5555 at SW16 and a subsequent empty FIFO, the same bits repeat.
3. Fill 16 frames. Required: fifo_level=16 and s_ready=0; a further s_valid is ignored. After the first pop, s_ready=1 on the next cycle.
4. NUM_CH=4, SLOT_W=16, SW16. Required: wclk low for 32 BCLKs (slots 0-1), then high for 32; the four lane values serialise in order.
5. Deassert enable at bit 10 of a frame. Required: the frame completes, one trailing bit is output, then busy=0 and bclk is held 0. Separately, assert reset mid-frame: all outputs are 0 on the next cycle and fifo_level=0.
6. Change sample_width from SW32 to SW16 mid-frame. Required: the current frame is sent at 32 bits and the next frame at 16 bits plus 16 zeros.
